decode_stage: RTL and testbench

Instruction-decode pipeline stage sitting directly upstream of the register file. It drives the register file's read addresses from the incoming instruction, decodes main control, sign-extends the immediate, and captures everything into the ID/EX pipeline register. Also owns load-use hazard detection (stall request to fetch), branch flush bubbling, and a write-back bypass so a same-cycle register write is seen by the decoding instruction.

---
 rtl/mips_pkg.sv | 51 +++++
 rtl/decode_stage_if.sv | 19 +
 rtl/main_control.sv | 43 ++++
 rtl/decode_stage.sv | 132 +++++++++++++
 tb/tb_decode_stage.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS-32 decode definitions: opcodes, ALU op encodings,
// the main-control bundle and the ID/EX pipeline register layout.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       reg_dst;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic        branch;
    logic [1:0]  alu_op;
    logic        illegal;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  write_reg;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] imm;
    logic [31:0] pc_plus4;
  } id_ex_t;

  // Opcodes whose rt field is a source operand, not a destination.
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// IF/ID-to-decode handshake bundle: instruction, valid, PC+4,
// flush from branch resolution, and the stall returned to fetch.
interface decode_stage_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc_plus4;
  logic        flush;
  logic        stall;

  modport master (
    output instr, instr_valid, pc_plus4, flush,
    input  stall
  );

  modport slave (
    input  instr, instr_valid, pc_plus4, flush,
    output stall
  );
endinterface

// File: rtl/main_control.sv
// Purely combinational MIPS main-control decoder:
// opcode in, control bundle out; unknown opcodes flag illegal.
module main_control
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (1'b1)
      (opcode == OP_RTYPE): begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      (opcode == OP_LW): begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = ALUOP_ADD;
      end
      (opcode == OP_SW): begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      (opcode == OP_BEQ): begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALUOP_SUB;
      end
      (opcode == OP_ADDI): begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS-32 instruction decode stage: register read addressing,
// WB bypass, load-use stall, flush bubbling and the ID/EX register.
module decode_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instrIn,
  input  logic        instrValid,
  input  logic [31:0] pcPlus4In,
  input  logic        flush,
  output logic        stallOut,
  output logic [4:0]  readReg1,
  output logic [4:0]  readReg2,
  input  logic [31:0] RegData1,
  input  logic [31:0] RegData2,
  input  logic        wbRegWrite,
  input  logic [4:0]  wbWriteReg,
  input  logic [31:0] wbWriteData,
  output logic        exValid,
  output logic        exRegWrite,
  output logic        exMemRead,
  output logic        exMemWrite,
  output logic        exMemToReg,
  output logic        exALUSrc,
  output logic        exBranch,
  output logic [1:0]  exALUOp,
  output logic [4:0]  exRs,
  output logic [4:0]  exRt,
  output logic [4:0]  exWriteReg,
  output logic [31:0] exData1,
  output logic [31:0] exData2,
  output logic [31:0] exImm,
  output logic [31:0] exPcPlus4,
  output logic        exIllegal
);

  ctrl_t       ctrl;
  id_ex_t      id_ex_d;
  id_ex_t      id_ex_q;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        hazard;
  logic [31:0] data1;
  logic [31:0] data2;

  assign opcode   = instrIn[31:26];
  assign rs       = instrIn[25:21];
  assign rt       = instrIn[20:16];
  assign rd       = instrIn[15:11];
  assign readReg1 = rs;
  assign readReg2 = rt;

  main_control u_main_control (
    .opcode (opcode),
    .ctrl   (ctrl)
  );

  always_comb begin
    hazard = instrValid && id_ex_q.valid
          && id_ex_q.mem_read
          && (id_ex_q.write_reg != 5'd0)
          && ((id_ex_q.write_reg == rs)
           || ((id_ex_q.write_reg == rt)
            && uses_rt(opcode)));
  end

  assign stallOut = hazard && !flush;

  // $0 is hard zero; a same-cycle WB write wins over the RF read.
  always_comb begin
    data1 = RegData1;
    data2 = RegData2;
    if (wbRegWrite && wbWriteReg == rs)
      data1 = wbWriteData;
    if (wbRegWrite && wbWriteReg == rt)
      data2 = wbWriteData;
    if (rs == 5'd0)
      data1 = '0;
    if (rt == 5'd0)
      data2 = '0;
  end

  always_comb begin
    id_ex_d = '0;
    if (instrValid && !flush && !hazard) begin
      id_ex_d.valid      = 1'b1;
      id_ex_d.reg_write  = ctrl.reg_write;
      id_ex_d.mem_read   = ctrl.mem_read;
      id_ex_d.mem_write  = ctrl.mem_write;
      id_ex_d.mem_to_reg = ctrl.mem_to_reg;
      id_ex_d.alu_src    = ctrl.alu_src;
      id_ex_d.branch     = ctrl.branch;
      id_ex_d.alu_op     = ctrl.alu_op;
      id_ex_d.illegal    = ctrl.illegal;
      id_ex_d.rs         = rs;
      id_ex_d.rt         = rt;
      id_ex_d.write_reg  = ctrl.reg_dst ? rd : rt;
      id_ex_d.data1      = data1;
      id_ex_d.data2      = data2;
      id_ex_d.imm        = {{16{instrIn[15]}}, instrIn[15:0]};
      id_ex_d.pc_plus4   = pcPlus4In;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      id_ex_q <= '0;
    else
      id_ex_q <= id_ex_d;
  end

  assign exValid    = id_ex_q.valid;
  assign exRegWrite = id_ex_q.reg_write;
  assign exMemRead  = id_ex_q.mem_read;
  assign exMemWrite = id_ex_q.mem_write;
  assign exMemToReg = id_ex_q.mem_to_reg;
  assign exALUSrc   = id_ex_q.alu_src;
  assign exBranch   = id_ex_q.branch;
  assign exALUOp    = id_ex_q.alu_op;
  assign exIllegal  = id_ex_q.illegal;
  assign exRs       = id_ex_q.rs;
  assign exRt       = id_ex_q.rt;
  assign exWriteReg = id_ex_q.write_reg;
  assign exData1    = id_ex_q.data1;
  assign exData2    = id_ex_q.data2;
  assign exImm      = id_ex_q.imm;
  assign exPcPlus4  = id_ex_q.pc_plus4;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed test-plan cases then random
// traffic, all checked against a behavioural next-state model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  readReg1, readReg2;
  logic [31:0] RegData1, RegData2;
  logic        wbRegWrite;
  logic [4:0]  wbWriteReg;
  logic [31:0] wbWriteData;
  logic        exValid, exRegWrite, exMemRead, exMemWrite;
  logic        exMemToReg, exALUSrc, exBranch, exIllegal;
  logic [1:0]  exALUOp;
  logic [4:0]  exRs, exRt, exWriteReg;
  logic [31:0] exData1, exData2, exImm, exPcPlus4;

  decode_stage_if bus ();

  always #5 clk = ~clk;

  decode_stage dut (
    .clk         (clk),
    .rst         (rst),
    .instrIn     (bus.instr),
    .instrValid  (bus.instr_valid),
    .pcPlus4In   (bus.pc_plus4),
    .flush       (bus.flush),
    .stallOut    (bus.stall),
    .readReg1    (readReg1),
    .readReg2    (readReg2),
    .RegData1    (RegData1),
    .RegData2    (RegData2),
    .wbRegWrite  (wbRegWrite),
    .wbWriteReg  (wbWriteReg),
    .wbWriteData (wbWriteData),
    .exValid     (exValid),
    .exRegWrite  (exRegWrite),
    .exMemRead   (exMemRead),
    .exMemWrite  (exMemWrite),
    .exMemToReg  (exMemToReg),
    .exALUSrc    (exALUSrc),
    .exBranch    (exBranch),
    .exALUOp     (exALUOp),
    .exRs        (exRs),
    .exRt        (exRt),
    .exWriteReg  (exWriteReg),
    .exData1     (exData1),
    .exData2     (exData2),
    .exImm       (exImm),
    .exPcPlus4   (exPcPlus4),
    .exIllegal   (exIllegal)
  );

  // Expected contents of the ID/EX register.
  typedef struct {
    bit        v, rw, mr, mw, m2r, as, br, ill;
    bit [1:0]  aop;
    bit [4:0]  rs, rt, wr;
    bit [31:0] d1, d2, imm, pc;
  } model_t;

  model_t m;
  int     n_pass = 0;
  int     n_total = 0;
  bit     st_obs;
  bit     st_exp;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic bit [31:0] enc_r(int rs, int rt, int rd);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
  endfunction

  function automatic bit [31:0] enc_i(bit [5:0] op, int rs,
                                      int rt, bit [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic bit model_hazard();
    int op, rs, rt;
    bit rt_src;
    op = int'(bus.instr[31:26]);
    rs = int'(bus.instr[25:21]);
    rt = int'(bus.instr[20:16]);
    rt_src = (op == 'h00) || (op == 'h2B) || (op == 'h04);
    return bus.instr_valid && m.v && m.mr && m.wr != 0
        && (m.wr == rs || (rt_src && m.wr == rt));
  endfunction

  function automatic bit [31:0] model_read(int r, bit [31:0] rf);
    if (r == 0) return 0;
    if (wbRegWrite && int'(wbWriteReg) == r) return wbWriteData;
    return rf;
  endfunction

  function automatic model_t model_next();
    model_t n;
    int op;
    n = '{default: 0};
    if (rst || !bus.instr_valid || bus.flush || model_hazard())
      return n;
    op = int'(bus.instr[31:26]);
    n.v = 1;
    case (op)
      'h00: begin n.rw = 1; n.aop = 2; end
      'h23: begin n.rw = 1; n.mr = 1; n.m2r = 1; n.as = 1; end
      'h2B: begin n.mw = 1; n.as = 1; end
      'h04: begin n.br = 1; n.aop = 1; end
      'h08: begin n.rw = 1; n.as = 1; end
      default: n.ill = 1;
    endcase
    n.rs  = bus.instr[25:21];
    n.rt  = bus.instr[20:16];
    n.wr  = (op == 0) ? bus.instr[15:11] : bus.instr[20:16];
    n.d1  = model_read(int'(n.rs), RegData1);
    n.d2  = model_read(int'(n.rt), RegData2);
    n.imm = 32'($signed(bus.instr[15:0]));
    n.pc  = bus.pc_plus4;
    return n;
  endfunction

  task automatic check_ex();
    chk("exValid",    exValid,    m.v);
    chk("exRegWrite", exRegWrite, m.rw);
    chk("exMemRead",  exMemRead,  m.mr);
    chk("exMemWrite", exMemWrite, m.mw);
    chk("exMemToReg", exMemToReg, m.m2r);
    chk("exALUSrc",   exALUSrc,   m.as);
    chk("exBranch",   exBranch,   m.br);
    chk("exIllegal",  exIllegal,  m.ill);
    chk("exALUOp",    exALUOp,    m.aop);
    chk("exRs",       exRs,       m.rs);
    chk("exRt",       exRt,       m.rt);
    chk("exWriteReg", exWriteReg, m.wr);
    chk("exData1",    exData1,    m.d1);
    chk("exData2",    exData2,    m.d2);
    chk("exImm",      exImm,      m.imm);
    chk("exPcPlus4",  exPcPlus4,  m.pc);
  endtask

  // Inputs are applied 1 ns after a rising edge; combinational
  // outputs are sampled mid-cycle, registered ones after the edge.
  task automatic cycle(bit pre = 1);
    model_t nx;
    #3;
    st_exp = model_hazard() && !bus.flush;
    st_obs = bus.stall;
    if (pre) begin
      chk("stallOut", bus.stall, st_exp);
      chk("readReg1", readReg1, bus.instr[25:21]);
      chk("readReg2", readReg2, bus.instr[20:16]);
    end
    nx = model_next();
    @(posedge clk);
    #1;
    m = nx;
    check_ex();
  endtask

  task automatic drive(bit [31:0] ins, bit val = 1, bit fl = 0,
                       bit [31:0] r1 = 0, bit [31:0] r2 = 0);
    bus.instr       = ins;
    bus.instr_valid = val;
    bus.flush       = fl;
    bus.pc_plus4    = $urandom;
    RegData1        = r1;
    RegData2        = r2;
  endtask

  task automatic wb(bit w, int r, bit [31:0] d);
    wbRegWrite  = w;
    wbWriteReg  = 5'(r);
    wbWriteData = d;
  endtask

  initial begin
    bit [31:0] ins;
    m = '{default: 0};
    rst = 1;
    wb(0, 0, 0);
    drive(enc_r(1, 2, 3), 1, 0, 9, 9);
    cycle(0);
    cycle();
    chk("rst_valid", exValid, 0);
    chk("rst_stall", st_obs, 0);
    rst = 0;

    drive(enc_r(1, 2, 3), 1, 0, 5, 7);
    cycle();
    chk("add_rw", exRegWrite, 1);
    chk("add_aop", exALUOp, 2'b10);
    chk("add_wr", exWriteReg, 3);
    chk("add_d1", exData1, 5);
    chk("add_d2", exData2, 7);

    drive(enc_i(6'h23, 1, 4, 16'd8));
    cycle();
    drive(enc_r(4, 2, 5), 1, 0, 11, 22);
    cycle();
    chk("lu_stall", st_obs, 1);
    chk("lu_bubble", exValid, 0);
    cycle();
    chk("lu_release", st_obs, 0);
    chk("lu_valid", exValid, 1);
    chk("lu_rs", exRs, 4);

    drive(enc_i(6'h08, 20, 6, 16'hFFFF), 1, 0, 0, 3);
    wb(1, 20, 50);
    cycle();
    chk("byp_d1", exData1, 50);
    chk("byp_imm", exImm, 32'hFFFF_FFFF);
    wb(0, 0, 0);

    drive(enc_i(6'h23, 1, 7, 16'd0));
    cycle();
    drive(enc_i(6'h04, 7, 2, 16'd4), 1, 1);
    cycle();
    chk("fl_stall", st_obs, 0);
    chk("fl_valid", exValid, 0);
    chk("fl_branch", exBranch, 0);

    drive({6'h3F, 26'h0123456});
    cycle();
    chk("ill_valid", exValid, 1);
    chk("ill_flag", exIllegal, 1);
    chk("ill_rw", exRegWrite, 0);

    // Reset arriving while a load-use stall is pending.
    drive(enc_i(6'h23, 2, 9, 16'd4));
    cycle();
    drive(enc_i(6'h2B, 3, 9, 16'd0));
    rst = 1;
    cycle();
    chk("rstall_stall", st_obs, 1);
    rst = 0;
    cycle();
    chk("rstall_clear", st_obs, 0);

    for (int i = 0; i < 600; i++) begin
      if (!st_exp) begin
        case ($urandom_range(0, 5))
          0: ins = enc_r($urandom_range(0, 7), $urandom_range(0, 7),
                         $urandom_range(0, 7));
          1: ins = enc_i(6'h23, $urandom_range(0, 7),
                         $urandom_range(0, 7), 16'($urandom));
          2: ins = enc_i(6'h2B, $urandom_range(0, 7),
                         $urandom_range(0, 7), 16'($urandom));
          3: ins = enc_i(6'h04, $urandom_range(0, 7),
                         $urandom_range(0, 7), 16'($urandom));
          4: ins = enc_i(6'h08, $urandom_range(0, 7),
                         $urandom_range(0, 7), 16'($urandom));
          default: ins = $urandom;
        endcase
      end else begin
        ins = bus.instr;
      end
      drive(ins, $urandom_range(0, 9) != 0,
            $urandom_range(0, 9) == 0, $urandom, $urandom);
      wb($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom);
      rst = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
